// File: rtl/csa_result_checker_if.sv
// Bus between the carry-select adder response checker and its environment:
// run control, sampled adder operands and results, and status/capture outputs.
interface csa_result_checker_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             clear;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [WIDTH:0]   fail_expect;
    logic [WIDTH:0]   fail_actual;

    modport master (
        output start, clear, a_in, b_in, cin_in, sum_in, cout_in,
        input  busy, done, error, pass_cnt, err_cnt, fail_expect, fail_actual
    );

    modport slave (
        input  start, clear, a_in, b_in, cin_in, sum_in, cout_in,
        output busy, done, error, pass_cnt, err_cnt, fail_expect, fail_actual
    );
endinterface

// File: rtl/csa_result_checker.sv
// Response checker for a carry-select adder: golden sum, latency-matched compare,
// saturating pass/error counts and first-failure capture. Option: CSA_CHK_STOP_ON_ERR_EN.
module csa_result_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LATENCY     = 0,
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    csa_result_checker_if.slave bus
);
    localparam int unsigned      VEC_W     = (NUM_VECTORS < 2) ? 1 : $clog2(NUM_VECTORS);
    localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NUM_VECTORS - 1);
    localparam logic [2:0]       FILL_LAST = 3'((LATENCY == 0) ? 0 : LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {StIdle, StFill, StCheck, StDone} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_compare;
    logic             w_start_run;
    logic [WIDTH:0]   w_exp;
    logic [WIDTH:0]   w_exp_cmp;
    logic [WIDTH:0]   w_act;
    logic             w_mismatch;
    logic [2:0]       r_fill_cnt;
    logic [VEC_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_error;
    logic [WIDTH:0]   r_fail_expect;
    logic [WIDTH:0]   r_fail_actual;

    // Full WIDTH+1 result so the carry out is checked, never truncated.
    assign w_exp = {1'b0, bus.a_in} + {1'b0, bus.b_in} + {{WIDTH{1'b0}}, bus.cin_in};
    assign w_act = {bus.cout_in, bus.sum_in};
    assign w_mismatch = (w_exp_cmp != w_act);

    generate
        if (LATENCY == 0) begin : g_no_delay
            assign w_exp_cmp = w_exp;
        end else begin : g_delay
            logic [WIDTH:0] r_dly [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(LATENCY); i++) r_dly[i] <= '0;
                end else if (bus.clear) begin
                    for (int i = 0; i < int'(LATENCY); i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= w_exp;
                    for (int i = 1; i < int'(LATENCY); i++) r_dly[i] <= r_dly[i-1];
                end
            end

            assign w_exp_cmp = r_dly[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_compare    = 1'b0;
        w_start_run  = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (bus.start) begin
                    w_start_run  = 1'b1;
                    w_state_next = (LATENCY == 0) ? StCheck : StFill;
                end
            end
            StFill: begin
                if (r_fill_cnt == FILL_LAST) w_state_next = StCheck;
            end
            StCheck: begin
                w_compare = 1'b1;
                if (r_vec_cnt == VEC_LAST) w_state_next = StDone;
`ifdef CSA_CHK_STOP_ON_ERR_EN
                if (w_mismatch) w_state_next = StDone;
`endif
            end
            default: w_state_next = StIdle;
        endcase
        // Clear wins over start and over any compare in the same cycle.
        if (bus.clear) begin
            w_state_next = StIdle;
            w_compare    = 1'b0;
            w_start_run  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt    <= '0;
            r_vec_cnt     <= '0;
            r_pass_cnt    <= '0;
            r_err_cnt     <= '0;
            r_error       <= 1'b0;
            r_fail_expect <= '0;
            r_fail_actual <= '0;
        end else if (bus.clear) begin
            r_fill_cnt    <= '0;
            r_vec_cnt     <= '0;
            r_pass_cnt    <= '0;
            r_err_cnt     <= '0;
            r_error       <= 1'b0;
            r_fail_expect <= '0;
            r_fail_actual <= '0;
        end else begin
            if (r_state == StFill) r_fill_cnt <= r_fill_cnt + 3'd1;
            else                   r_fill_cnt <= '0;

            if (w_start_run)    r_vec_cnt <= '0;
            else if (w_compare) r_vec_cnt <= r_vec_cnt + VEC_W'(1);

            if (w_compare) begin
                if (w_mismatch) begin
                    if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
                    r_error <= 1'b1;
                    // Only the first failure since clear is kept.
                    if (r_err_cnt == '0) begin
                        r_fail_expect <= w_exp_cmp;
                        r_fail_actual <= w_act;
                    end
                end else if (r_pass_cnt != CNT_MAX) begin
                    r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy        = (r_state == StFill) || (r_state == StCheck);
    assign bus.done        = (r_state == StDone);
    assign bus.error       = r_error;
    assign bus.pass_cnt    = r_pass_cnt;
    assign bus.err_cnt     = r_err_cnt;
    assign bus.fail_expect = r_fail_expect;
    assign bus.fail_actual = r_fail_actual;

endmodule

// File: tb/tb_csa_result_checker.sv
// Bench for csa_result_checker: randomized operands, fault injection, latency
// variants and counter saturation against a plain-arithmetic reference model.
module tb_csa_result_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, clear, cin;
    logic [7:0] a, b;
    logic [8:0] flip0;
    logic [8:0] gold, p1, p2;
    int         errors = 0;
    int         checks = 0;

    // Reference model state for dut0
    int         m_pass, m_err, m_ncmp, m_done_at;
    logic [8:0] m_fexp, m_fact;
    bit         m_stopped;

    always #5 clk = ~clk;

    csa_result_checker_if #(.WIDTH(8), .CNT_W(16)) if0 (), if1 (), if2 ();
    csa_result_checker_if #(.WIDTH(8), .CNT_W(4))  ifs ();

    assign gold = 9'(a) + 9'(b) + 9'(cin);

    // Two-stage registered adder feeding the latency variants
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p1 <= gold;
            p2 <= p1;
        end
    end

    assign {if0.start, if0.clear, if0.a_in, if0.b_in, if0.cin_in} = {start, clear, a, b, cin};
    assign {if1.start, if1.clear, if1.a_in, if1.b_in, if1.cin_in} = {start, clear, a, b, cin};
    assign {if2.start, if2.clear, if2.a_in, if2.b_in, if2.cin_in} = {start, clear, a, b, cin};
    assign {ifs.start, ifs.clear, ifs.a_in, ifs.b_in, ifs.cin_in} = {start, clear, a, b, cin};
    assign {if0.cout_in, if0.sum_in} = gold ^ flip0;
    assign {if1.cout_in, if1.sum_in} = p2;
    assign {if2.cout_in, if2.sum_in} = p2;
    assign {ifs.cout_in, ifs.sum_in} = gold ^ 9'h001;

    csa_result_checker #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(256), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    csa_result_checker #(.WIDTH(8), .LATENCY(1), .NUM_VECTORS(32), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    csa_result_checker #(.WIDTH(8), .LATENCY(2), .NUM_VECTORS(32), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));
    csa_result_checker #(.WIDTH(8), .LATENCY(0), .NUM_VECTORS(20), .CNT_W(4)) duts (
        .clk(clk), .rst_n(rst_n), .bus(ifs.slave));

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_clear();
        m_pass = 0; m_err = 0; m_fexp = '0; m_fact = '0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_clear();
    endtask

    // One 256-vector run on dut0; optional fault on vector bad_idx. Observes, never judges.
    task automatic run_vectors(input int bad_idx, input logic [8:0] bad_mask,
                               input logic [7:0] ba, input logic [7:0] bb, input logic bc,
                               output int done_at, output int busy_bad, output int busy2);
        logic [8:0] e, x;
        m_stopped = 0; m_ncmp = 0; m_done_at = 256;
        done_at = -1; busy_bad = 0; busy2 = 0;
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); start = 1'b0;
            if (done_at < 0 && if0.done === 1'b1) done_at = i;
            if (if0.busy !== (m_stopped ? 1'b0 : 1'b1)) busy_bad++;
            if (if2.busy === 1'b1) busy2++;
            if (i == bad_idx) begin
                a = ba; b = bb; cin = bc; flip0 = bad_mask;
            end else begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); flip0 = '0;
            end
            if (!m_stopped) begin
                e = 9'(a) + 9'(b) + 9'(cin);
                x = e ^ flip0;
                m_ncmp++;
                if (x == e) m_pass = sat_inc(m_pass, 65535);
                else begin
                    if (m_err == 0) begin m_fexp = e; m_fact = x; end
                    m_err = sat_inc(m_err, 65535);
`ifdef CSA_CHK_STOP_ON_ERR_EN
                    m_stopped = 1; m_done_at = m_ncmp;
`endif
                end
            end
        end
        @(negedge clk); flip0 = '0;
        if (done_at < 0 && if0.done === 1'b1) done_at = 256;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if0.busy); end
        checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", if0.done); end
        checks++; if (if0.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", if0.error); end
        checks++; if (if0.pass_cnt !== 16'd0) begin errors++; $display("FAIL reset_pass got %0d want 0", if0.pass_cnt); end
        checks++; if (if0.err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err got %0d want 0", if0.err_cnt); end
        checks++; if (if0.fail_expect !== 9'h0 || if0.fail_actual !== 9'h0) begin
            errors++; $display("FAIL reset_capture got %h/%h want 0/0", if0.fail_expect, if0.fail_actual);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_run();
        int done_at, busy_bad, busy2, exp_sat;
        model_clear();
        run_vectors(-1, 9'h0, 8'h0, 8'h0, 1'b0, done_at, busy_bad, busy2);
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL clean_busy bad_cycles=%0d want 0", busy_bad); end
        checks++; if (done_at !== m_done_at) begin errors++; $display("FAIL clean_done_at got %0d want %0d", done_at, m_done_at); end
        checks++; if (if0.pass_cnt !== 16'(m_pass)) begin errors++; $display("FAIL clean_pass got %0d want %0d", if0.pass_cnt, m_pass); end
        checks++; if (if0.err_cnt !== 16'd0 || if0.error !== 1'b0) begin
            errors++; $display("FAIL clean_err got %0d/%b want 0/0", if0.err_cnt, if0.error);
        end
        checks++; if (busy2 !== 34) begin errors++; $display("FAIL lat2_busy got %0d want 34", busy2); end
        checks++; if (if2.err_cnt !== 16'd0 || if2.pass_cnt !== 16'd32) begin
            errors++; $display("FAIL lat2_counts got err=%0d pass=%0d want 0/32", if2.err_cnt, if2.pass_cnt);
        end
        checks++; if (if1.err_cnt === 16'd0) begin errors++; $display("FAIL lat1_err got 0 want nonzero"); end
`ifdef CSA_CHK_STOP_ON_ERR_EN
        exp_sat = 1;
`else
        exp_sat = 15;
`endif
        checks++; if (ifs.err_cnt !== 4'(exp_sat) || ifs.pass_cnt !== 4'd0 || ifs.done !== 1'b1) begin
            errors++; $display("FAIL sat_err got err=%0d pass=%0d done=%b want %0d/0/1",
                               ifs.err_cnt, ifs.pass_cnt, ifs.done, exp_sat);
        end
    endtask

    task automatic test_single_fault();
        int done_at, busy_bad, busy2;
        do_clear();
        run_vectors(10, 9'h001, 8'h0B, 8'h47, 1'b0, done_at, busy_bad, busy2);
        checks++; if (done_at !== m_done_at) begin errors++; $display("FAIL fault_done_at got %0d want %0d", done_at, m_done_at); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL fault_busy bad_cycles=%0d want 0", busy_bad); end
        checks++; if (if0.err_cnt !== 16'd1 || if0.error !== 1'b1) begin
            errors++; $display("FAIL fault_err got %0d/%b want 1/1", if0.err_cnt, if0.error);
        end
        checks++; if (if0.pass_cnt !== 16'(m_pass)) begin errors++; $display("FAIL fault_pass got %0d want %0d", if0.pass_cnt, m_pass); end
        checks++; if (if0.fail_expect !== 9'h052 || if0.fail_actual !== 9'h053) begin
            errors++; $display("FAIL fault_capture got %h/%h want 052/053", if0.fail_expect, if0.fail_actual);
        end
    endtask

    task automatic test_back_to_back();
        int done_at, busy_bad, busy2;
        run_vectors(-1, 9'h0, 8'h0, 8'h0, 1'b0, done_at, busy_bad, busy2);
        checks++; if (done_at !== m_done_at) begin errors++; $display("FAIL b2b_done_at got %0d want %0d", done_at, m_done_at); end
        checks++; if (if0.pass_cnt !== 16'(m_pass)) begin errors++; $display("FAIL b2b_pass got %0d want %0d", if0.pass_cnt, m_pass); end
        checks++; if (if0.err_cnt !== 16'(m_err) || if0.error !== 1'b1) begin
            errors++; $display("FAIL b2b_err got %0d/%b want %0d/1", if0.err_cnt, if0.error, m_err);
        end
        checks++; if (if0.fail_expect !== m_fexp || if0.fail_actual !== m_fact) begin
            errors++; $display("FAIL b2b_capture got %h/%h want %h/%h", if0.fail_expect, if0.fail_actual, m_fexp, m_fact);
        end
    endtask

    task automatic test_carry_wrap();
        int done_at, busy_bad, busy2;
        do_clear();
        run_vectors(3, 9'h100, 8'hFF, 8'hFF, 1'b1, done_at, busy_bad, busy2);
        checks++; if (if0.fail_expect !== 9'h1FF || if0.fail_actual !== 9'h0FF) begin
            errors++; $display("FAIL wrap_capture got %h/%h want 1ff/0ff", if0.fail_expect, if0.fail_actual);
        end
        checks++; if (if0.err_cnt !== 16'(m_err) || if0.pass_cnt !== 16'(m_pass)) begin
            errors++; $display("FAIL wrap_counts got err=%0d pass=%0d want %0d/%0d",
                               if0.err_cnt, if0.pass_cnt, m_err, m_pass);
        end
    endtask

    task automatic test_clear_start_midrun();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; flip0 = 9'h001;
        repeat (6) @(negedge clk);
        flip0 = '0;
        checks++; if (if0.busy !== 1'b1 || if0.err_cnt === 16'd0) begin
            errors++; $display("FAIL midrun_live got busy=%b err=%0d want 1/nonzero", if0.busy, if0.err_cnt);
        end
        clear = 1'b1; start = 1'b1;
        @(negedge clk); clear = 1'b0; start = 1'b0;
        checks++; if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin
            errors++; $display("FAIL clrstart_state got busy=%b done=%b want 0/0", if0.busy, if0.done);
        end
        checks++; if (if0.pass_cnt !== 16'd0 || if0.err_cnt !== 16'd0 || if0.error !== 1'b0) begin
            errors++; $display("FAIL clrstart_counts got pass=%0d err=%0d error=%b want 0/0/0",
                               if0.pass_cnt, if0.err_cnt, if0.error);
        end
        checks++; if (if0.fail_expect !== 9'h0 || if0.fail_actual !== 9'h0) begin
            errors++; $display("FAIL clrstart_capture got %h/%h want 0/0", if0.fail_expect, if0.fail_actual);
        end
        @(negedge clk);
        checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL clrstart_idle got busy=%b want 0", if0.busy); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; flip0 = 9'h001;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.error !== 1'b0) begin
            errors++; $display("FAIL rstmid_state got busy=%b done=%b error=%b want 0/0/0",
                               if0.busy, if0.done, if0.error);
        end
        checks++; if (if0.err_cnt !== 16'd0 || if0.pass_cnt !== 16'd0 || if0.fail_actual !== 9'h0) begin
            errors++; $display("FAIL rstmid_counts got err=%0d pass=%0d act=%h want 0/0/0",
                               if0.err_cnt, if0.pass_cnt, if0.fail_actual);
        end
        @(negedge clk); rst_n = 1'b1; flip0 = '0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        a = '0; b = '0; cin = 1'b0; flip0 = '0;
        model_clear();
        test_reset();
        test_clean_run();
        test_single_fault();
        test_back_to_back();
        test_carry_wrap();
        test_clear_start_midrun();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
